window_control: RTL and testbench

WINDOW_CONTROL -- requirements
Module: window_control

---
 rtl/window_control.sv | 155 +++++++++++++++
 tb/tb_window_control.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/window_control.sv
// 3x3 sliding-window generator over four rotating 256-pixel line buffers.
// Optional macro WINDOW_CTRL_INTR_EN enables the one-cycle line-freed interrupt.

module line_buffer #(
  parameter int unsigned LINE_WIDTH = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_in_data_valid,
  input  logic        i_read_data,
  output logic [23:0] o_data
);
  localparam int unsigned AW = $clog2(LINE_WIDTH);

  logic [7:0]    r_mem [LINE_WIDTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] w_rd_p1;
  logic [AW-1:0] w_rd_p2;

  // Storage is not reset; only the pointers are, so stale data is simply overwritten.
  always_ff @(posedge i_clk) begin
    if (i_in_data_valid && !i_rst) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_in_data_valid) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_read_data)     r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Taps wrap modulo the line, so the last two windows pick up columns 0 and 1.
  assign w_rd_p1 = r_rd_ptr + AW'(1);
  assign w_rd_p2 = r_rd_ptr + AW'(2);
  assign o_data  = {r_mem[r_rd_ptr], r_mem[w_rd_p1], r_mem[w_rd_p2]};
endmodule

module window_control #(
  parameter int unsigned LINE_WIDTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_in_valid,
  output logic        in_ready,
  output logic [71:0] window_out,
  output logic        window_valid,
  output logic        intr
);
  typedef enum logic [0:0] {StIdle, StRead} state_e;

  localparam logic [10:0] FillFull  = 11'(4 * LINE_WIDTH);
  localparam logic [10:0] FillThree = 11'(3 * LINE_WIDTH);
  localparam logic [7:0]  LastCol   = 8'(LINE_WIDTH - 1);

  state_e      r_state;
  state_e      w_state_d;
  logic [1:0]  r_wr_sel;
  logic [1:0]  r_rd_sel;
  logic [7:0]  r_wr_cnt;
  logic [7:0]  r_rd_cnt;
  logic [10:0] r_fill;
  logic        w_wr;
  logic        w_rd;
  logic        w_buf_rst;
  logic [1:0]  w_skip;
  logic [3:0]  w_wr_en;
  logic [3:0]  w_rd_en;
  logic [23:0] w_buf_data [4];

  assign w_rd      = (r_state == StRead);
  assign in_ready  = (r_fill < FillFull) || w_rd;
  assign w_wr      = pixel_in_valid && in_ready;
  assign w_buf_rst = ~rst;
  assign w_skip    = r_rd_sel + 2'd3;
  assign w_wr_en   = w_wr ? (4'b0001 << r_wr_sel) : 4'b0000;
  assign w_rd_en   = w_rd ? (4'b1111 & ~(4'b0001 << w_skip)) : 4'b0000;

  for (genvar i = 0; i < 4; i++) begin : g_buf
    line_buffer #(
      .LINE_WIDTH (LINE_WIDTH)
    ) u_line_buffer (
      .i_clk           (clk),
      .i_rst           (w_buf_rst),
      .i_data          (pixel_in),
      .i_in_data_valid (w_wr_en[i]),
      .i_read_data     (w_rd_en[i]),
      .o_data          (w_buf_data[i])
    );
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (r_fill >= FillThree) w_state_d = StRead;
      StRead:  if (r_rd_cnt == LastCol) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_wr_sel <= '0;
      r_rd_sel <= '0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_fill   <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_wr) begin
        r_wr_cnt <= r_wr_cnt + 8'd1;
        if (r_wr_cnt == LastCol) r_wr_sel <= r_wr_sel + 2'd1;
      end
      if (w_rd) begin
        r_rd_cnt <= r_rd_cnt + 8'd1;
        if (r_rd_cnt == LastCol) r_rd_sel <= r_rd_sel + 2'd1;
      end
      if (w_wr && !w_rd) begin
        r_fill <= r_fill + 11'd1;
      end else if (!w_wr && w_rd) begin
        r_fill <= r_fill - 11'd1;
      end
    end
  end

  // Oldest line on top: rd_sel feeds the most significant row.
  assign window_valid = w_rd;
  assign window_out   = w_rd ? {w_buf_data[r_rd_sel],
                                w_buf_data[r_rd_sel + 2'd1],
                                w_buf_data[r_rd_sel + 2'd2]} : 72'd0;

`ifdef WINDOW_CTRL_INTR_EN
  logic r_intr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_intr <= 1'b0;
    end else begin
      r_intr <= w_rd && (r_rd_cnt == LastCol);
    end
  end

  assign intr = r_intr;
`else
  assign intr = 1'b0;
`endif
endmodule

// File: tb/tb_window_control.sv
// Randomised scoreboard bench for window_control against a line/column reference model.
// Honours WINDOW_CTRL_INTR_EN when deciding whether intr pulses are expected.

module tb_window_control;
  logic        clk;
  logic        rst;
  logic [7:0]  pixel_in;
  logic        pixel_in_valid;
  logic        in_ready;
  logic [71:0] window_out;
  logic        window_valid;
  logic        intr;

`ifdef WINDOW_CTRL_INTR_EN
  localparam bit IntrEn = 1'b1;
`else
  localparam bit IntrEn = 1'b0;
`endif

  window_control #(
    .LINE_WIDTH (256)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pixel_in       (pixel_in),
    .pixel_in_valid (pixel_in_valid),
    .in_ready       (in_ready),
    .window_out     (window_out),
    .window_valid   (window_valid),
    .intr           (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic wv;
    logic rdy;
    logic intr;
  } exp_t;

  exp_t        cyc_q[$];
  logic [71:0] win_q[$];
  int          n_chk;
  int          n_fail;

  // Reference state: pixels land in line slot (k/256)%4 at column k%256.
  logic [7:0] m_mem [4][256];
  int         m_fill;
  int         m_wk;
  int         m_rline;
  int         m_col;
  bit         m_reading;
  bit         m_intr;
  bit         did_rst;

  task automatic model_reset();
    m_fill    = 0;
    m_wk      = 0;
    m_rline   = 0;
    m_col     = 0;
    m_reading = 1'b0;
    m_intr    = 1'b0;
  endtask

  task automatic step(input logic v, input logic [7:0] px, input logic rn);
    exp_t        e;
    logic        acc;
    logic [71:0] w;
    int          fill_old;
    e.wv   = m_reading;
    e.rdy  = (m_fill < 1024) || m_reading;
    e.intr = m_intr;
    cyc_q.push_back(e);
    if (m_reading) begin
      for (int r = 0; r < 3; r++) begin
        for (int j = 0; j < 3; j++) begin
          w[71 - 24 * r - 8 * j -: 8] = m_mem[(m_rline + r) % 4][(m_col + j) % 256];
        end
      end
      win_q.push_back(w);
    end
    acc = v && e.rdy;
    if (!rn) begin
      model_reset();
    end else begin
      fill_old = m_fill;
      if (acc) begin
        m_mem[(m_wk / 256) % 4][m_wk % 256] = px;
        m_wk = (m_wk + 1) % 1024;
      end
      m_fill = m_fill + (acc ? 1 : 0) - (m_reading ? 1 : 0);
      m_intr = 1'b0;
      if (m_reading) begin
        m_col++;
        if (m_col == 256) begin
          m_reading = 1'b0;
          m_col     = 0;
          m_rline   = (m_rline + 1) % 4;
          m_intr    = IntrEn;
        end
      end else if (fill_old >= 768) begin
        m_reading = 1'b1;
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] px, input logic rn);
    pixel_in_valid = v;
    pixel_in       = px;
    rst            = rn;
    step(v, px, rn);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      exp_t e;
      e = cyc_q.pop_front();
      chk("window_valid", 72'(window_valid), 72'(e.wv));
      chk("in_ready", 72'(in_ready), 72'(e.rdy));
      chk("intr", 72'(intr), 72'(e.intr));
      if (window_valid === 1'b1) begin
        if (win_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL window_unexpected: got %h, expected no window", window_out);
        end else begin
          chk("window_out", window_out, win_q.pop_front());
        end
      end else begin
        chk("window_out_idle", window_out, 72'd0);
      end
    end
  end

  initial begin
    int pct;
    logic rn;
    n_chk          = 0;
    n_fail         = 0;
    did_rst        = 1'b0;
    rst            = 1'b0;
    pixel_in_valid = 1'b1;
    pixel_in       = 8'hAA;
    model_reset();
    @(posedge clk);
    #1;
    // Reset held with pixels offered: nothing must be stored.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hAA, 1'b0);

    // Three directed lines: 10+col, 20+col, 30+col.
    for (int k = 0; k < 768; k++) begin
      cycle(1'b1, 8'((k / 256 + 1) * 16 + (k % 256)), 1'b1);
    end
    for (int i = 0; i < 300; i++) cycle(1'b0, 8'h00, 1'b1);

    // Random streaming at several densities, with one reset mid-read.
    for (int seg = 0; seg < 4; seg++) begin
      pct = (seg == 0) ? 100 : (seg == 1) ? 60 : (seg == 2) ? 90 : 30;
      for (int i = 0; i < 1200; i++) begin
        rn = 1'b1;
        if (!did_rst && seg == 1 && m_reading && m_col == 100) begin
          rn      = 1'b0;
          did_rst = 1'b1;
        end
        cycle(($urandom_range(0, 99) < 32'(pct)), 8'($urandom), rn);
      end
    end
    for (int i = 0; i < 600; i++) cycle(1'b0, 8'h00, 1'b1);

    @(negedge clk);
    @(negedge clk);
    chk("cycle_queue_drained", 72'(cyc_q.size()), 72'd0);
    chk("window_queue_drained", 72'(win_q.size()), 72'd0);
    chk("mid_read_reset_hit", 72'(did_rst), 72'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
